// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and MEM-stage loads/stores.
// Define ARB_TIMEOUT_EN to abort accesses the memory never acknowledges (sets sticky timeout_err).
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic [2:0]    d_read,
    input  logic [1:0]    d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic [2:0]    mem_rtype,
    output logic          mem_fetch,
    output logic [1:0]    mem_wtype,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IBUSY = 2'd1;
    localparam logic [1:0] ST_DBUSY = 2'd2;

    logic [1:0] state;
    logic       last_data;
    logic       fetch_pend;
    logic       data_pend;
    logic       grant_data;
    logic       grant_fetch;
    logic       busy;
    logic       abort;

    // A requester whose ready pulse is showing has a stale request and must not be re-granted.
    assign stall_if   = if_req && !if_ready;
    assign stall_mem  = ((d_read != 3'd0) || (d_write != 2'd0)) && !d_ready;
    assign fetch_pend = stall_if;
    assign data_pend  = stall_mem;
    assign busy       = (state != ST_IDLE);

    assign grant_data  = !busy && data_pend && (!fetch_pend || !last_data);
    assign grant_fetch = !busy && fetch_pend && !grant_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] busy_cnt;

    // The final busy cycle without an acknowledge is the one that brings the count to TIMEOUT.
    assign abort = busy && !mem_ack && (busy_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (grant_data || grant_fetch) begin
            busy_cnt <= '0;
        end else if (busy && !mem_ack) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_data <= 1'b0;
            mem_req   <= 1'b0;
            mem_fetch <= 1'b0;
            mem_rtype <= 3'd0;
            mem_wtype <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        state     <= ST_DBUSY;
                        mem_req   <= 1'b1;
                        mem_fetch <= 1'b0;
                        mem_rtype <= d_read;
                        mem_wtype <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_fetch) begin
                        state     <= ST_IBUSY;
                        mem_req   <= 1'b1;
                        mem_fetch <= 1'b1;
                        mem_rtype <= 3'd0;
                        mem_wtype <= 2'd0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ST_IBUSY: begin
                    if (mem_ack || abort) begin
                        state     <= ST_IDLE;
                        mem_req   <= 1'b0;
                        if_ready  <= 1'b1;
                        if_rdata  <= mem_ack ? mem_rdata : '0;
                        last_data <= 1'b0;
                    end
                end
                ST_DBUSY: begin
                    if (mem_ack || abort) begin
                        state     <= ST_IDLE;
                        mem_req   <= 1'b0;
                        d_ready   <= 1'b1;
                        last_data <= 1'b1;
                        // Stores leave the previous load data visible.
                        if (!mem_ack) begin
                            d_rdata <= '0;
                        end else if (mem_rtype != 3'd0) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences, then
// randomized pipeline/memory traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [2:0]  d_read;
    logic [1:0]  d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic [2:0]  mem_rtype;
    logic        mem_fetch;
    logic [1:0]  mem_wtype;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_rtype(mem_rtype), .mem_fetch(mem_fetch),
        .mem_wtype(mem_wtype), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic [2:0]  d_read;
        logic [1:0]  d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        exp_stall_if;
        logic        exp_stall_mem;
        logic        exp_mem_req;
        logic        exp_mem_fetch;
        logic [31:0] exp_mem_addr;
        logic        exp_if_ready;
        logic        exp_d_ready;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [8];

    // Reference model of the port, kept at transaction level.
    logic        m_req, m_fetch, m_last_data, m_if_ready, m_d_ready;
    logic [2:0]  m_rtype;
    logic [1:0]  m_wtype;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    int          lat_left;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        d_read    = v.d_read;
        d_write   = v.d_write;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_ack   = v.mem_ack;
        mem_rdata = v.mem_rdata;
    endtask

    // Expects a freshly granted access; acks it after lat cycles and checks the ready cycle.
    task automatic serveOne(input string nm, input int lat, input logic [31:0] rd,
                            input logic exp_fetch, input logic [31:0] exp_addr);
        checkBit({nm, " mem_req"}, mem_req, 1'b1);
        checkBit({nm, " mem_fetch"}, mem_fetch, exp_fetch);
        checkOutput({nm, " mem_addr"}, mem_addr, exp_addr);
        for (int i = 1; i < lat; i++) tick();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        checkBit({nm, " req drop"}, mem_req, 1'b0);
        if (exp_fetch) begin
            checkBit({nm, " if_ready"}, if_ready, 1'b1);
            checkOutput({nm, " if_rdata"}, if_rdata, rd);
        end else begin
            checkBit({nm, " d_ready"}, d_ready, 1'b1);
            checkOutput({nm, " d_rdata"}, d_rdata, rd);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_read = '0; d_write = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick();
        tick();
        checkBit("rst mem_req", mem_req, 1'b0);
        checkBit("rst mem_fetch", mem_fetch, 1'b0);
        checkOutput("rst mem_rtype", 32'(mem_rtype), 32'd0);
        checkOutput("rst mem_wtype", 32'(mem_wtype), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst mem_wdata", mem_wdata, 32'd0);
        checkBit("rst if_ready", if_ready, 1'b0);
        checkBit("rst d_ready", d_ready, 1'b0);
        checkOutput("rst if_rdata", if_rdata, 32'd0);
        checkOutput("rst d_rdata", d_rdata, 32'd0);
        checkBit("rst timeout_err", timeout_err, 1'b0);
        rst = 1'b0;

        // Fetch only, then simultaneous fetch+load with data winning, then an idle ack.
        vecs[0] = '{1'b1, 32'h4, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 32'h4, 3'd0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0010_0093,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0010_0093, 32'h0};
        vecs[2] = '{1'b0, 32'h4, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0010_0093, 32'h0};
        vecs[3] = '{1'b1, 32'h8, 3'b010, 2'd0, 32'h100, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0010_0093, 32'h0};
        vecs[4] = '{1'b1, 32'h8, 3'b010, 2'd0, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF,
                    1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h8, 3'b010, 2'd0, 32'h100, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 32'h8, 3'd0, 2'd0, 32'h100, 32'h0, 1'b1, 32'h1111_1111,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 32'h8, 3'd0, 2'd0, 32'h100, 32'h0, 1'b1, 32'h1234_5678,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkBit($sformatf("vec%0d stall_if", i), stall_if, vecs[i].exp_stall_if);
            checkBit($sformatf("vec%0d stall_mem", i), stall_mem, vecs[i].exp_stall_mem);
            tick();
            checkBit($sformatf("vec%0d mem_req", i), mem_req, vecs[i].exp_mem_req);
            if (vecs[i].exp_mem_req) begin
                checkBit($sformatf("vec%0d mem_fetch", i), mem_fetch, vecs[i].exp_mem_fetch);
                checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_mem_addr);
            end
            checkBit($sformatf("vec%0d if_ready", i), if_ready, vecs[i].exp_if_ready);
            checkBit($sformatf("vec%0d d_ready", i), d_ready, vecs[i].exp_d_ready);
            checkOutput($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
            checkOutput($sformatf("vec%0d d_rdata", i), d_rdata, vecs[i].exp_d_rdata);
        end
        mem_ack = 1'b0;
        if_req  = 1'b0;

        // Store acknowledged on its fourth busy cycle; the request address wiggles meanwhile.
        d_write = 2'b11; d_addr = 32'h200; d_wdata = 32'hA5A5_A5A5;
        tick();
        for (int i = 1; i <= 4; i++) begin
            checkBit($sformatf("store c%0d mem_req", i), mem_req, 1'b1);
            checkBit($sformatf("store c%0d mem_fetch", i), mem_fetch, 1'b0);
            checkOutput($sformatf("store c%0d mem_wtype", i), 32'(mem_wtype), 32'd3);
            checkOutput($sformatf("store c%0d mem_addr", i), mem_addr, 32'h200);
            checkOutput($sformatf("store c%0d mem_wdata", i), mem_wdata, 32'hA5A5_A5A5);
            d_addr    = $urandom;
            mem_ack   = (i == 4);
            mem_rdata = 32'hFFFF_0000;
            tick();
        end
        mem_ack = 1'b0;
        checkBit("store d_ready", d_ready, 1'b1);
        checkBit("store req drop", mem_req, 1'b0);
        checkOutput("store d_rdata kept", d_rdata, 32'hDEAD_BEEF);
        d_write = 2'd0;
        tick();
        checkBit("store pulse width", d_ready, 1'b0);

        // Last completion was data, so fetch wins first; then strict alternation with stale requests.
        if_req = 1'b1; if_addr = 32'h3C; d_read = 3'b010; d_addr = 32'h300;
        tick();
        serveOne("alt g1", 1, 32'h0000_0013, 1'b1, 32'h3C);
        if_addr = 32'h40;
        tick();
        serveOne("alt g2", 2, 32'hCAFE_0001, 1'b0, 32'h300);
        d_addr = 32'h304;
        tick();
        serveOne("alt g3", 1, 32'h0000_0033, 1'b1, 32'h40);
        tick();
        serveOne("alt g4", 3, 32'hCAFE_0002, 1'b0, 32'h304);
        if_req = 1'b0; d_read = 3'd0;
        tick();
        checkBit("alt idle mem_req", mem_req, 1'b0);

        // Reset in the middle of a data access.
        d_read = 3'b010; d_addr = 32'h500;
        tick();
        checkBit("rstmid granted", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkBit("rstmid mem_req async", mem_req, 1'b0);
        d_read = 3'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkBit($sformatf("rstmid post%0d d_ready", i), d_ready, 1'b0);
            checkBit($sformatf("rstmid post%0d mem_req", i), mem_req, 1'b0);
        end

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort after eight busy cycles.
        d_read = 3'b001; d_addr = 32'h600;
        tick();
        for (int i = 1; i <= 8; i++) begin
            checkBit($sformatf("tmo busy%0d mem_req", i), mem_req, 1'b1);
            tick();
        end
        checkBit("tmo mem_req drop", mem_req, 1'b0);
        checkBit("tmo d_ready", d_ready, 1'b1);
        checkOutput("tmo d_rdata", d_rdata, 32'd0);
        checkBit("tmo timeout_err", timeout_err, 1'b1);
        d_read = 3'd0;
        tick();
        tick();
        checkBit("tmo sticky", timeout_err, 1'b1);
`endif

        // Randomized traffic against the reference model.
        rst = 1'b1;
        if_req = 1'b0; d_read = '0; d_write = '0; mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        m_req = 1'b0; m_fetch = 1'b0; m_last_data = 1'b0; m_if_ready = 1'b0; m_d_ready = 1'b0;
        m_rtype = '0; m_wtype = '0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
        lat_left = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic f_pend, d_pend, d_active;

            if (if_req && m_if_ready) begin
                if ($urandom_range(1, 0) == 0) if_req = 1'b0;
                else if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (!if_req && $urandom_range(3, 0) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end

            d_active = (d_read != 3'd0) || (d_write != 2'd0);
            if ((d_active && m_d_ready) || (!d_active && $urandom_range(3, 0) == 0)) begin
                if (d_active && $urandom_range(1, 0) == 0) begin
                    d_read = 3'd0; d_write = 2'd0;
                end else if ($urandom_range(1, 0) == 0) begin
                    d_read = 3'($urandom_range(7, 1)); d_write = 2'd0;
                end else begin
                    d_read = 3'd0; d_write = 2'($urandom_range(3, 1));
                end
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if (m_req && !m_fetch && $urandom_range(3, 0) == 0) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end

            mem_rdata = $urandom;
            if (m_req) begin
                mem_ack = (lat_left == 0);
                if (lat_left > 0) lat_left--;
            end else begin
                mem_ack = ($urandom_range(7, 0) == 0);
            end

            #1;
            f_pend = if_req && !m_if_ready;
            d_pend = ((d_read != 3'd0) || (d_write != 2'd0)) && !m_d_ready;
            checkBit("rnd stall_if", stall_if, f_pend);
            checkBit("rnd stall_mem", stall_mem, d_pend);

            m_if_ready = 1'b0;
            m_d_ready  = 1'b0;
            if (!m_req) begin
                if (d_pend && !(f_pend && m_last_data)) begin
                    m_req = 1'b1; m_fetch = 1'b0; m_rtype = d_read; m_wtype = d_write;
                    m_addr = d_addr; m_wdata = d_wdata;
                    lat_left = int'($urandom_range(3, 0));
                end else if (f_pend) begin
                    m_req = 1'b1; m_fetch = 1'b1; m_rtype = 3'd0; m_wtype = 2'd0;
                    m_addr = if_addr;
                    lat_left = int'($urandom_range(3, 0));
                end
            end else if (mem_ack) begin
                m_req = 1'b0;
                if (m_fetch) begin
                    m_if_ready = 1'b1; m_if_rdata = mem_rdata; m_last_data = 1'b0;
                end else begin
                    m_d_ready = 1'b1; m_last_data = 1'b1;
                    if (m_rtype != 3'd0) m_d_rdata = mem_rdata;
                end
            end

            tick();
            checkBit("rnd mem_req", mem_req, m_req);
            if (m_req) begin
                checkBit("rnd mem_fetch", mem_fetch, m_fetch);
                checkOutput("rnd mem_addr", mem_addr, m_addr);
                checkOutput("rnd mem_rtype", 32'(mem_rtype), 32'(m_rtype));
                checkOutput("rnd mem_wtype", 32'(mem_wtype), 32'(m_wtype));
                if (!m_fetch) checkOutput("rnd mem_wdata", mem_wdata, m_wdata);
            end
            checkBit("rnd if_ready", if_ready, m_if_ready);
            checkBit("rnd d_ready", d_ready, m_d_ready);
            checkOutput("rnd if_rdata", if_rdata, m_if_rdata);
            checkOutput("rnd d_rdata", d_rdata, m_d_rdata);
            checkBit("rnd timeout_err", timeout_err, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
